fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of a `myfifo` instance among C_NUM_SRC producers.
- Each producer uses a valid/ready/data handshake. The winner holds the port for a burst of up to C_MAX_BURST beats.
- Arbitration is zero-latency: the data path is a mux with no register stage.
- A lock register keeps the selection stable while the output stalls and while a burst is in progress.
- Sits between producer blocks and the FIFO's write_valid/write_ready/write_data.

---
 rtl/fifo_write_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares one FIFO write port
// among C_NUM_SRC valid/ready producers. A winner may hold the port for up to
// C_MAX_BURST beats. Selection is combinational, so the data path has zero
// latency, and a lock register pins the grant across stalls and bursts.
module fifo_write_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_NUM_SRC    = 4,
  parameter int C_MAX_BURST  = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [C_NUM_SRC-1:0]                s_valid,
  output logic [C_NUM_SRC-1:0]                s_ready,
  input  logic [C_NUM_SRC*C_DATA_WIDTH-1:0]   s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [C_DATA_WIDTH-1:0]             m_data,
  output logic [$clog2(C_NUM_SRC)-1:0]        m_src,
  output logic                                busy
);

  localparam int SW = $clog2(C_NUM_SRC);
  localparam int BW = $clog2(C_MAX_BURST + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_t;

  lock_t         lock_q;
  logic [SW-1:0] owner_q;
  logic [SW-1:0] last_q;
  logic [BW-1:0] beat_q;

  logic [SW-1:0] scan_sel;
  logic [SW-1:0] sel;
  logic          sel_valid;
  logic          owner_valid;
  logic          xfer;
  logic [BW:0]   beat_inc;
  logic          burst_end;

  // Round-robin scan starting one past the last released source.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand     = 0;
    found    = 1'b0;
    scan_sel = SW'((32'(last_q) + 1) % C_NUM_SRC);
    for (int unsigned i = 1; i <= C_NUM_SRC; i++) begin
      cand = (32'(last_q) + i) % C_NUM_SRC;
      if (!found && s_valid[SW'(cand)]) begin
        scan_sel = SW'(cand);
        found    = 1'b1;
      end
    end
  end

  // Locked grant wins over the scan; reset forces source 0 so outputs drop
  // without waiting for an edge.
  always_comb begin
    sel = '0;
    if (resetn) begin
      sel = (lock_q == LOCKED) ? owner_q : scan_sel;
    end
  end

  // Output mux and per-source handshake decode.
  always_comb begin
    m_data      = '0;
    sel_valid   = 1'b0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < C_NUM_SRC; i++) begin
      if (sel == SW'(i)) begin
        m_data    = s_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_valid = s_valid[i];
      end
      if (owner_q == SW'(i)) begin
        owner_valid = s_valid[i];
      end
    end
    m_valid = resetn & sel_valid;
    xfer    = m_valid & m_ready;
    s_ready = '0;
    for (int unsigned i = 0; i < C_NUM_SRC; i++) begin
      s_ready[i] = xfer && (sel == SW'(i));
    end
    m_src     = sel;
    busy      = (lock_q == LOCKED);
    beat_inc  = {1'b0, beat_q} + (BW+1)'(1);
    burst_end = (beat_inc == (BW+1)'(C_MAX_BURST));
  end

  // Grant lock, owner, round-robin pointer and burst beat counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q  <= UNLOCKED;
      owner_q <= '0;
      last_q  <= SW'(C_NUM_SRC - 1);
      beat_q  <= '0;
    end else if (xfer && burst_end) begin
      lock_q  <= UNLOCKED;
      beat_q  <= '0;
      last_q  <= sel;
    end else if (xfer) begin
      lock_q  <= LOCKED;
      owner_q <= sel;
      beat_q  <= beat_inc[BW-1:0];
    end else if (m_valid && !m_ready) begin
      lock_q  <= LOCKED;
      owner_q <= sel;
    end else if (lock_q == LOCKED && !owner_valid) begin
      lock_q  <= UNLOCKED;
      beat_q  <= '0;
      last_q  <= owner_q;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer queues feed the sources,
// and the expected (source, data) order of accepted beats is pushed to a
// scoreboard queue and popped on each observed transfer.
module tb_fifo_write_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] data;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [255:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic [1:0]   m_src;
  logic         busy;

  logic [3:0]   s_valid1;
  logic [3:0]   s_ready1;
  logic [255:0] s_data1;
  logic         m_valid1;
  logic         m_ready1;
  logic [63:0]  m_data1;
  logic [1:0]   m_src1;
  logic         busy1;

  int checks   = 0;
  int failures = 0;

  logic [63:0] srcq [4][$];
  exp_t        expq [$];

  logic        smp_valid;
  logic        smp_xfer;
  logic        smp_busy;
  logic [1:0]  smp_src;
  logic [63:0] smp_data;

  fifo_write_arbiter #(
    .C_DATA_WIDTH(64),
    .C_NUM_SRC   (4),
    .C_MAX_BURST (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_src  (m_src),
    .busy   (busy)
  );

  fifo_write_arbiter #(
    .C_DATA_WIDTH(64),
    .C_NUM_SRC   (4),
    .C_MAX_BURST (1)
  ) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .s_valid(s_valid1),
    .s_ready(s_ready1),
    .s_data (s_data1),
    .m_valid(m_valid1),
    .m_ready(m_ready1),
    .m_data (m_data1),
    .m_src  (m_src1),
    .busy   (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int s, input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) srcq[s].push_back(base + 64'(k));
  endtask

  task automatic expect_beat(input int s, input logic [63:0] d);
    exp_t e;
    e.src  = 2'(s);
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_valid[i]         = (srcq[i].size() != 0);
      s_data[i*64 +: 64] = (srcq[i].size() != 0) ? srcq[i][0] : 64'h0;
    end
  endtask

  // Called at posedge+1; samples at posedge+4 and returns at next posedge+1.
  task automatic cycle();
    exp_t e;
    drive();
    #3;
    smp_valid = m_valid;
    smp_xfer  = m_valid && m_ready;
    smp_busy  = busy;
    smp_src   = m_src;
    smp_data  = m_data;
    chk("s_ready_decode", 64'(s_ready), smp_xfer ? 64'(4'b0001 << m_src) : 64'h0);
    if (smp_xfer) begin
      if (expq.size() == 0) begin
        chk("unexpected_xfer", 64'(smp_src), 64'hFF);
      end else begin
        e = expq.pop_front();
        chk("xfer_src", 64'(smp_src), 64'(e.src));
        chk("xfer_data", smp_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    if (smp_xfer) void'(srcq[smp_src].pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(expq.size()), 64'h0);
  endtask

  initial begin
    int nx;
    int exp_s;

    // Reset: outputs held low / source 0 regardless of requests and ready.
    resetn   = 1'b0;
    m_ready  = 1'b1;
    s_valid  = 4'b0100;
    s_data   = '0;
    s_data[63:0]    = 64'hDEAD_0000;
    s_data[191:128] = 64'h2222;
    s_valid1 = 4'b0000;
    m_ready1 = 1'b1;
    s_data1  = '0;
    for (int i = 0; i < 4; i++) s_data1[i*64 +: 64] = 64'hB0 + 64'(i);
    #2;
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_m_src", 64'(m_src), 64'h0);
    chk("rst_m_data", m_data, 64'hDEAD_0000);
    s_valid = '0;
    s_data  = '0;
    #10;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // All four sources busy: bursts of 4 rotating 0,1,2,3 then back to 0.
    for (int s = 0; s < 4; s++) load(s, 5, 64'(s) << 8);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) expect_beat(s, (64'(s) << 8) + 64'(k));
    for (int s = 0; s < 4; s++) expect_beat(s, (64'(s) << 8) + 64'd4);
    nx = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (smp_xfer) nx++;
    end
    chk("t1_16_xfers_in_16", 64'(nx), 64'd16);
    cycle();
    chk("t1_17th_src", 64'(smp_src), 64'h0);
    chk("t1_17th_xfer", 64'(smp_xfer), 64'h1);
    drain("t1_drain", 40);
    cycle();

    // Single source 2, six beats: no bubble across the burst boundary.
    load(2, 6, 64'h2000);
    for (int k = 0; k < 6; k++) expect_beat(2, 64'h2000 + 64'(k));
    nx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (smp_xfer) nx++;
    end
    chk("t2_6_consecutive", 64'(nx), 64'd6);
    cycle();
    cycle();

    // Stall with FIFO full: grant and data pinned on source 1.
    m_ready = 1'b0;
    srcq[1].push_back(64'hA5);
    load(1, 3, 64'hA6);
    for (int k = 0; k < 4; k++) expect_beat(1, 64'hA5 + 64'(k));
    expect_beat(0, 64'hC0);
    cycle();
    chk("t3_stall_src", 64'(smp_src), 64'h1);
    chk("t3_stall_data", smp_data, 64'hA5);
    chk("t3_stall_valid", 64'(smp_valid), 64'h1);
    srcq[0].push_back(64'hC0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("t3_hold_src", 64'(smp_src), 64'h1);
      chk("t3_hold_data", smp_data, 64'hA5);
      chk("t3_hold_busy", 64'(smp_busy), 64'h1);
    end
    m_ready = 1'b1;
    drain("t3_drain", 20);
    cycle();

    // Owner 3 goes idle mid-burst: one bubble, then 0, then rotate past 0.
    load(3, 2, 64'h300);
    load(0, 5, 64'h10);
    expect_beat(3, 64'h300);
    expect_beat(3, 64'h301);
    for (int k = 0; k < 4; k++) expect_beat(0, 64'h10 + 64'(k));
    cycle();
    cycle();
    cycle();
    chk("t4_bubble", 64'(smp_valid), 64'h0);
    srcq[2].push_back(64'h200);
    expect_beat(2, 64'h200);
    expect_beat(0, 64'h14);
    drain("t4_drain", 30);
    cycle();

    // C_MAX_BURST=1: per-beat round robin between sources 0 and 2.
    s_valid1 = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      exp_s = (k % 2 == 1) ? 2 : 0;
      #3;
      chk("t5_src", 64'(m_src1), 64'(exp_s));
      chk("t5_valid", 64'(m_valid1), 64'h1);
      chk("t5_ready", 64'(s_ready1), 64'(4'b0001 << exp_s));
      chk("t5_data", m_data1, 64'hB0 + 64'(exp_s));
      @(posedge clk);
      #1;
    end
    s_valid1 = 4'b0000;

    // Reset mid-burst of source 1: outputs drop asynchronously.
    load(1, 4, 64'h500);
    expect_beat(1, 64'h500);
    cycle();
    drive();
    #2;
    chk("t6_pre_busy", 64'(busy), 64'h1);
    chk("t6_pre_src", 64'(m_src), 64'h1);
    resetn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(m_valid), 64'h0);
    chk("t6_async_ready", 64'(s_ready), 64'h0);
    chk("t6_async_busy", 64'(busy), 64'h0);
    chk("t6_async_src", 64'(m_src), 64'h0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
    drive();
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      srcq[s].push_back(64'h600 + 64'(s));
      expect_beat(s, 64'h600 + 64'(s));
    end
    cycle();
    chk("t6_first_grant", 64'(smp_src), 64'h0);
    drain("t6_drain", 20);
    for (int s = 0; s < 4; s++) chk("final_srcq_empty", 64'(srcq[s].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
